// File: rtl/irqc_pkg.sv
// irqc_pkg: register word indices, source ID type and bus response states shared by wb_irq_ctrl
package irqc_pkg;
    localparam logic [1:0] IRQC_PENDING = 2'd0;
    localparam logic [1:0] IRQC_ENABLE  = 2'd1;
    localparam logic [1:0] IRQC_CLAIM   = 2'd2;
    localparam int IRQC_ID_W = 5;
    typedef logic [IRQC_ID_W-1:0] irqc_id_t;
    typedef enum logic [1:0] {BUS_IDLE, BUS_ACK, BUS_ERR} bus_state_t;
endpackage

// File: rtl/irqc_gateway.sv
// irqc_gateway: per-source pending latch with edge or level triggering
//   clk_i, rst_i     clock, async active-high reset
//   src_i            interrupt line (already synchronous to clk_i)
//   in_service_i     source is currently claimed
//   claim_i          claim read is clearing this source now
//   pending_o        latched pending bit
module irqc_gateway #(
    parameter bit IS_EDGE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
    input  logic in_service_i,
    input  logic claim_i,
    output logic pending_o
);
    logic prev;
    logic set;
    // Level sources hold off while in service so they re-pend only after complete.
    assign set = IS_EDGE ? src_i & ~prev : src_i & ~in_service_i;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev      <= 1'b0;
            pending_o <= 1'b0;
        end else begin
            prev      <= src_i;
            // Edge: a new edge beats the claim clear; level: the clear wins.
            pending_o <= IS_EDGE ? set | (pending_o & ~claim_i) : (pending_o | set) & ~claim_i;
        end
    end
endmodule

// File: rtl/wb_irq_ctrl.sv
// wb_irq_ctrl: Wishbone external interrupt controller with claim/complete handshake
//   clk_i, rst_i     clock, async active-high reset
//   wb_*             Wishbone slave: word 0 PENDING, 1 ENABLE, 2 CLAIM/COMPLETE, 3 error
//   irq_src_i        raw interrupt lines, bit i is source ID i+1
//   irq_o            registered request to the core
//   Define WB_IRQ_CTRL_SYNC_EN to add a 2-flop synchronizer on every irq_src_i bit.
module wb_irq_ctrl
    import irqc_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter logic [NUM_SOURCES-1:0] EDGE_MASK = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [1:0]             wb_addr_i,
    input  logic [31:0]            wb_wdata_i,
    input  logic [3:0]             wb_sel_i,
    output logic                   wb_stall_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic [31:0]            wb_rdata_o,
    input  logic [NUM_SOURCES-1:0] irq_src_i,
    output logic                   irq_o
);
    logic [NUM_SOURCES-1:0] src, pending, enable, in_service, eligible, claim_oh, done_oh;
    irqc_id_t claim_id, done_id;
    logic accept, claim, complete;
    bus_state_t state, state_nx;
    logic [31:0] rdata_q, rdata_nx;
    logic unused;
    assign unused = ^{wb_sel_i, wb_wdata_i};
`ifdef WB_IRQ_CTRL_SYNC_EN
    logic [NUM_SOURCES-1:0] sync_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) {src, sync_q} <= '0;
        else {src, sync_q} <= {sync_q, irq_src_i};
    end
`else
    assign src = irq_src_i;
`endif
    assign wb_stall_o = 1'b0;
    assign accept     = wb_cyc_i & wb_stb_i;
    assign claim      = accept & ~wb_we_i & (wb_addr_i == IRQC_CLAIM);
    assign complete   = accept & wb_we_i & (wb_addr_i == IRQC_CLAIM);
    assign done_id    = wb_wdata_i[IRQC_ID_W-1:0];
    assign eligible   = pending & enable & ~in_service;
    // Fixed priority: scanning downward leaves the lowest eligible ID.
    always_comb begin
        claim_id = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--)
            if (eligible[i]) claim_id = irqc_id_t'(i + 1);
    end
    for (genvar g = 0; g < NUM_SOURCES; g++) begin : gen_src
        assign claim_oh[g] = claim && claim_id == irqc_id_t'(g + 1);
        assign done_oh[g]  = complete && done_id == irqc_id_t'(g + 1);
        irqc_gateway #(.IS_EDGE(EDGE_MASK[g])) u_gw (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .src_i        (src[g]),
            .in_service_i (in_service[g]),
            .claim_i      (claim_oh[g]),
            .pending_o    (pending[g])
        );
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable     <= '0;
            in_service <= '0;
            irq_o      <= 1'b0;
        end else begin
            if (accept && wb_we_i && wb_addr_i == IRQC_ENABLE) enable <= wb_wdata_i[NUM_SOURCES-1:0];
            in_service <= (in_service | claim_oh) & ~done_oh;
            irq_o      <= |eligible;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= BUS_IDLE;
            rdata_q <= '0;
        end else begin
            state   <= state_nx;
            rdata_q <= rdata_nx;
        end
    end
    always_comb begin
        state_nx = !accept ? BUS_IDLE : (wb_addr_i == 2'd3) ? BUS_ERR : BUS_ACK;
        rdata_nx = '0;
        if (accept && !wb_we_i)
            rdata_nx = wb_addr_i == IRQC_PENDING ? 32'(pending) :
                       wb_addr_i == IRQC_ENABLE  ? 32'(enable)  :
                       wb_addr_i == IRQC_CLAIM   ? 32'(claim_id) : '0;
    end
    // Response is dropped if the master abandons the cycle.
    always_comb begin
        wb_ack_o   = (state == BUS_ACK) & wb_cyc_i;
        wb_err_o   = (state == BUS_ERR) & wb_cyc_i;
        wb_rdata_o = wb_ack_o ? rdata_q : '0;
    end
endmodule

// File: tb/tb_wb_irq_ctrl.sv
// tb_wb_irq_ctrl: directed and randomized checks of wb_irq_ctrl against a behavioural model
module tb_wb_irq_ctrl;
    localparam int N = 4;
    localparam logic [N-1:0] EM = 4'b0001;
    logic clk = 0, rst = 0, cyc = 0, stb = 0, we = 0;
    logic [1:0] addr = 0;
    logic [31:0] wdata = 0;
    logic [3:0] sel = 4'hF;
    logic [N-1:0] src = 0;
    logic stall, ack, err, irq;
    logic [31:0] rdata;
    logic [31:0] r;
    logic ak, er;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    wb_irq_ctrl #(.NUM_SOURCES(N), .EDGE_MASK(EM)) dut (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_addr_i(addr), .wb_wdata_i(wdata), .wb_sel_i(sel), .wb_stall_o(stall),
        .wb_ack_o(ack), .wb_err_o(err), .wb_rdata_o(rdata), .irq_src_i(src), .irq_o(irq)
    );

    bit [N-1:0] m_pend, m_en, m_ins, m_prev;
    bit m_irq, m_ack, m_err;
    bit [31:0] m_rdata;

    always @(posedge clk or posedge rst) begin : model
        bit [N-1:0] elig, np, nins;
        int id, cid;
        bit acc, clm;
        if (rst) begin
            m_pend = 0; m_en = 0; m_ins = 0; m_prev = 0;
            m_irq = 0; m_ack = 0; m_err = 0; m_rdata = 0;
        end else begin
            elig = m_pend & m_en & ~m_ins;
            id = 0;
            for (int i = N; i >= 1; i--) if (elig[i-1]) id = i;
            acc = cyc && stb;
            clm = acc && !we && addr == 2 && id != 0;
            m_ack = acc && addr != 3;
            m_err = acc && addr == 3;
            m_rdata = 0;
            if (acc && !we)
                case (addr)
                    2'd0: m_rdata = 32'(m_pend);
                    2'd1: m_rdata = 32'(m_en);
                    2'd2: m_rdata = id;
                    default: m_rdata = 0;
                endcase
            np = m_pend;
            nins = m_ins;
            if (clm) begin np[id-1] = 0; nins[id-1] = 1; end
            cid = int'(wdata[4:0]);
            if (acc && we && addr == 2 && cid >= 1 && cid <= N) nins[cid-1] = 0;
            if (acc && we && addr == 1) m_en = wdata[N-1:0];
            for (int i = 0; i < N; i++)
                if (EM[i]) begin
                    if (src[i] && !m_prev[i]) np[i] = 1;
                end else if (src[i] && !m_ins[i] && !(clm && id == i + 1)) np[i] = 1;
            m_irq = |elig;
            m_prev = src;
            m_pend = np;
            m_ins = nins;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d, input logic drop,
                       output logic [31:0] ro, output logic ao, output logic eo);
        @(negedge clk); cyc = 1; stb = 1; we = w; addr = a; wdata = d;
        @(negedge clk); stb = 0; we = 0; if (drop) cyc = 0;
        #1;
        ro = rdata; ao = ack; eo = err;
        chk("bus_ack", 32'(ao), 32'(m_ack && !drop));
        chk("bus_err", 32'(eo), 32'(m_err && !drop));
        chk("bus_rdata", ro, (m_ack && !drop) ? m_rdata : 32'd0);
        chk("bus_irq", 32'(irq), 32'(m_irq));
        cyc = 0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] x; logic xa, xe;
        bus(0, a, 0, 0, x, xa, xe);
        chk(tag, x, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] x; logic xa, xe;
        bus(1, a, d, 0, x, xa, xe);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        chk("step_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic pulse0();
        @(negedge clk); src[0] = 1;
        @(negedge clk); src[0] = 0;
    endtask

    initial begin
        #1 rst = 1;
        #1;
        chk("rst_ack", 32'(ack), 0); chk("rst_err", 32'(err), 0);
        chk("rst_rdata", rdata, 0); chk("rst_irq", 32'(irq), 0); chk("stall", 32'(stall), 0);
        repeat (2) @(negedge clk); rst = 0;

        pulse0();
        wr(1, 32'h1);
        step(1); chk("pre_rst_irq", 32'(irq), 1);
        #2 rst = 1;
        #1 chk("async_rst_irq", 32'(irq), 0); chk("async_rst_ack", 32'(ack), 0); chk("async_rst_rdata", rdata, 0);
        @(negedge clk); rst = 0;
        rd(0, 0, "pend_after_rst");

        wr(1, 32'hF);
        @(negedge clk); src[0] = 1;
        @(negedge clk); src[0] = 0; chk("edge_irq_t1", 32'(irq), 0);
        @(negedge clk); chk("edge_irq_t2", 32'(irq), 1);
        rd(2, 1, "claim_edge");
        step(1); chk("irq_drop", 32'(irq), 0);
        rd(2, 0, "claim_empty");
        wr(2, 1);
        pulse0(); step(1);
        rd(2, 1, "claim_after_complete");
        wr(2, 1);

        src = 4'b1010;
        wr(1, 32'hA);
        rd(2, 2, "claim_l2");
        rd(2, 4, "claim_l4");
        wr(2, 2);
        rd(0, 2, "pend_reassert");
        rd(2, 2, "claim_l2_again");
        src = 0;
        wr(2, 2); wr(2, 4);

        wr(1, 0);
        src[2] = 1;
        step(3); chk("irq_disabled", 32'(irq), 0);
        rd(0, 4, "pend_disabled");
        rd(2, 0, "claim_disabled");
        wr(1, 4);
        step(1); chk("irq_enabled", 32'(irq), 1);
        src[2] = 0;
        rd(2, 3, "claim3");
        wr(2, 3);

        bus(0, 3, 0, 0, r, ak, er);
        chk("w3_err", 32'(er), 1); chk("w3_ack", 32'(ak), 0);
        bus(1, 2, 0, 0, r, ak, er); chk("complete0_ack", 32'(ak), 1);
        bus(1, 2, 7, 0, r, ak, er); chk("complete7_ack", 32'(ak), 1);
        rd(1, 4, "enable_kept");
        bus(0, 1, 0, 1, r, ak, er); chk("drop_ack", 32'(ak), 0);
        wr(0, 32'hF);
        rd(0, 0, "pend_ro");
        wr(1, 9);
        @(negedge clk); cyc = 1; stb = 1; we = 0; addr = 0;
        @(negedge clk); addr = 1; #1 chk("b2b_ack0", 32'(ack), 1); chk("b2b_d0", rdata, 0);
        @(negedge clk); stb = 0; #1 chk("b2b_ack1", 32'(ack), 1); chk("b2b_d1", rdata, 9);
        cyc = 0;

        wr(1, 32'hF);
        pulse0(); step(1);
        @(negedge clk); cyc = 1; stb = 1; we = 0; addr = 2; src[0] = 1;
        @(negedge clk); stb = 0; src[0] = 0;
        #1 chk("same_claim_ack", 32'(ack), 1); chk("same_claim_id", rdata, 1);
        cyc = 0;
        rd(0, 1, "same_pend_kept");
        step(1); chk("same_irq_masked", 32'(irq), 0);
        wr(2, 1);
        step(1); chk("same_irq_back", 32'(irq), 1);
        rd(2, 1, "same_claim_again");
        wr(2, 1);

        for (int k = 0; k < 400; k++) begin
            logic [1:0] a;
            logic w, dr;
            logic [31:0] d;
            src = 4'($urandom);
            a = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 2) == 0);
            d = (a == 2) ? 32'($urandom_range(0, 7)) : $urandom;
            dr = ($urandom_range(0, 9) == 0);
            bus(w, a, d, dr, r, ak, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_irq_ctrl.md
Name: wb_irq_ctrl

Overview:
- Wishbone-slave external interrupt controller. Sits on a crossbar slave port, downstream of the bus.
- Upstream of the core's irq_external_i input, which it drives.
- Collects peripheral interrupt lines (UART rx/tx/fifo, future blocks), latches them as pending and gates them by enables.
- Exposes a claim/complete handshake so firmware services one source at a time.

Parameters:
- NUM_SOURCES, 4, number of interrupt inputs; legal range 1..31; source IDs are 1..NUM_SOURCES.
- EDGE_MASK, '0 (NUM_SOURCES bits), bit i=1 makes source i rising-edge triggered; bit i=0 makes it level triggered.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_addr_i  in  2  word index (bus addr[3:2]).
- wb_wdata_i  in  32  write data.
- wb_sel_i  in  4  byte selects (ignored; full-word access).
- wb_stall_o  out  1  always 0.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  error for an unmapped word.
- wb_rdata_o  out  32  read data.
- irq_src_i  in  NUM_SOURCES  raw interrupt lines; bit i is ID i+1.
- irq_o  out  1  to core irq_external_i.

Behaviour:
- Reset (async on rst_i high): pending, enable, in_service, edge-history, wb_ack_o, wb_err_o, wb_rdata_o, irq_o all 0.
- Register map:
  - word 0: PENDING, RO.
  - word 1: ENABLE, RW, bits above NUM_SOURCES read 0.
  - word 2: CLAIM on read, COMPLETE on write.
  - word 3: unmapped, gives err.
- Bus:
  - Accept when cyc&stb; never stall.
  - Exactly one response 1 cycle later: ack for words 0-2, err (no ack, no side effect) for word 3.
  - rdata is valid with ack and 0 otherwise.
  - Register side effects happen in the accept cycle.
  - If cyc deasserts in the accept+1 cycle, ack/err is suppressed; side effects already taken stand.
  - Back-to-back accepts each cycle are supported.
- Gateway per source:
  - Edge source: pending set when irq_src_i=1 and previous sample=0.
  - Level source: pending set while irq_src_i=1.
  - Pending is set regardless of enable; enable gates only claim and irq.
- Eligible vector: pending & enable & ~in_service.
- Claim read:
  - Returns ID of lowest-numbered eligible source (fixed priority, ID 1 highest).
  - Sets its in_service bit and clears its pending bit.
  - No eligible source returns 0 with no state change.
- Complete write:
  - wdata[4:0]=ID clears in_service for that ID.
  - ID 0, ID >NUM_SOURCES, or ID not in service: ignored, still acked.
- Level source still high after complete: pending re-sets next cycle.
- Simultaneous pending-set and claim-clear on the same source:
  - Edge source: set wins, so the new edge is not lost.
  - Level source: clear wins, and the source is masked by in_service anyway.
- Simultaneous claim and complete cannot occur (single port).
- irq_o is registered: irq_o(t+1) = |eligible(t). Edge-to-irq_o latency is 2 cycles (edge sample, then irq register).
- irq_o drops 1 cycle after the claim read is accepted when no other source is eligible.
- Writes to PENDING are acked with no effect.

Optional Feature:
- Macro: WB_IRQ_CTRL_SYNC_EN.
- Defined: each irq_src_i bit passes through a 2-flop synchronizer (reset to 0) before the gateway; latency becomes 4 cycles. Allows asynchronous sources.
- Undefined: inputs are used directly; all sources must be synchronous to clk_i.

Decomposition:
- Package irqc_pkg: word-index localparams (IRQC_PENDING=0, IRQC_ENABLE=1, IRQC_CLAIM=2), IRQC_ID_W=5, typedef irqc_id_t.
- Sub-module irqc_gateway: one instance per source; edge/level parameter, edge history, pending set/clear logic; instantiated via generate.
- Top level holds the enable/in_service registers, the priority encoder and the bus FSM.

Test Plan:
- Reset mid-run: pend src1, ENABLE=1, assert rst_i asynchronously -> all outputs 0 immediately, PENDING read=0 after release.
- Edge src (EDGE_MASK=4'b0001), ENABLE=4'hF, pulse irq_src_i[0] 1 cycle -> irq_o=1 two cycles later; CLAIM read=1; irq_o=0 next cycle; second CLAIM=0; COMPLETE 1 -> in_service cleared.
- Level srcs 2 and 4 held high, ENABLE=4'hA -> CLAIM=2, then CLAIM=4; COMPLETE 2 with src2 still high -> PENDING bit1 reasserts, CLAIM=2 again.
- Disabled source: src3 high, ENABLE=0 -> irq_o stays 0, PENDING=0x4, CLAIM=0; set ENABLE=0x4 -> irq_o=1 within 1 cycle.
- Bus errors/edges: read word 3 -> err=1, ack=0; COMPLETE 0 and 7 -> acked, no state change; drop cyc in response cycle -> no ack; back-to-back reads PENDING, ENABLE -> two consecutive acks with correct data.
- Edge arriving in the same cycle as its claim (edge src) -> CLAIM returns ID, PENDING bit stays 1, irq_o reasserts after COMPLETE.
